// File: rtl/mont_batch_ctrl_if.sv
// Signal bundle between mont_batch_ctrl, its host and the Montgomery multiplier.
// The controller takes the slave view; the host and multiplier side takes the master view.
interface mont_batch_ctrl_if #(
    parameter int AW = 9,
    parameter int DW = 12
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_a;
    logic [DW-1:0] wr_b;
    logic          start;
    logic [AW:0]   len;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          ready;
    logic          finished;
    logic          error;
    logic          mul_en;
    logic [DW-1:0] mul_a;
    logic [DW-1:0] mul_b;
    logic          mul_busy;
    logic          mul_done;
    logic [DW-1:0] mul_r;

    modport slave (
        input  wr_en, wr_addr, wr_a, wr_b, start, len, rd_addr,
        input  mul_busy, mul_done, mul_r,
        output rd_data, ready, finished, error, mul_en, mul_a, mul_b
    );

    modport master (
        output wr_en, wr_addr, wr_a, wr_b, start, len, rd_addr,
        output mul_busy, mul_done, mul_r,
        input  rd_data, ready, finished, error, mul_en, mul_a, mul_b
    );
endinterface

// File: rtl/mont_batch_ctrl.sv
// Batch initiator for montgomery_top: streams buffered operand pairs one per cycle,
// collects the in-order results, and flags length, spurious-result and timeout errors.
module mont_batch_ctrl #(
    parameter int DEPTH   = 512,
    parameter int AW      = 9,
    parameter int DW      = 12,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    mont_batch_ctrl_if.slave  bus
);
    localparam int CW  = AW + 1;
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;

    state_e          r_state;
    state_e          w_next;

    logic [DW-1:0]   r_mem_a   [DEPTH];
    logic [DW-1:0]   r_mem_b   [DEPTH];
    logic [DW-1:0]   r_mem_res [DEPTH];

    logic [CW-1:0]   r_len;
    logic [CW-1:0]   r_issue_cnt;
    logic [CW-1:0]   r_sent_cnt;
    logic [CW-1:0]   r_ret_cnt;
    logic [WDW-1:0]  r_wdog;
    logic            r_issue_v;
    logic [DW-1:0]   r_op_a;
    logic [DW-1:0]   r_op_b;
    logic            r_mul_en;
    logic [DW-1:0]   r_mul_a;
    logic [DW-1:0]   r_mul_b;
    logic            r_finished;
    logic            r_error;
    logic [DW-1:0]   r_rd_data;

    logic            w_len_ok;
    logic            w_start_ok;
    logic            w_start_bad;
    logic            w_ret_ok;
    logic            w_spurious;
    logic            w_idle_cyc;
    logic            w_timeout;
    logic            w_issue;

    assign w_len_ok    = (bus.len != '0) && (bus.len <= CW'(DEPTH));
    assign w_start_ok  = (r_state == S_IDLE) && bus.start && w_len_ok;
    assign w_start_bad = (r_state == S_IDLE) && bus.start && !w_len_ok;
    assign w_ret_ok    = bus.mul_done && (r_state != S_IDLE) && (r_ret_cnt < r_len);
    assign w_spurious  = bus.mul_done && !w_ret_ok;
    // Watchdog only runs while results are owed and nothing moves on either side.
    assign w_idle_cyc  = (r_state != S_IDLE) && !r_mul_en && !bus.mul_done
                         && (r_sent_cnt > r_ret_cnt);
    assign w_timeout   = w_idle_cyc && (r_wdog == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start_ok)                         w_next = S_ISSUE;
            S_ISSUE: if (r_issue_cnt == r_len - CW'(1))      w_next = S_DRAIN;
            S_DRAIN: if (r_ret_cnt == r_len)                 w_next = S_IDLE;
            default:                                         w_next = S_IDLE;
        endcase
        if (w_timeout) w_next = S_IDLE;
    end

    always_comb begin
        w_issue      = (r_state == S_ISSUE);
        bus.ready    = (r_state == S_IDLE);
        bus.finished = r_finished;
        bus.error    = r_error;
        bus.mul_en   = r_mul_en;
        bus.mul_a    = r_mul_a;
        bus.mul_b    = r_mul_b;
        bus.rd_data  = r_rd_data;
    end

    // NOTE: buffer storage carries no reset so it maps onto block RAM; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (bus.wr_en && (r_state == S_IDLE)) begin
            r_mem_a[bus.wr_addr] <= bus.wr_a;
            r_mem_b[bus.wr_addr] <= bus.wr_b;
        end
        r_op_a <= r_mem_a[r_issue_cnt[AW-1:0]];
        r_op_b <= r_mem_b[r_issue_cnt[AW-1:0]];
        if (w_ret_ok) r_mem_res[r_ret_cnt[AW-1:0]] <= bus.mul_r;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_rd_data <= '0;
        else        r_rd_data <= r_mem_res[bus.rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_sent_cnt  <= '0;
            r_ret_cnt   <= '0;
            r_wdog      <= '0;
            r_issue_v   <= 1'b0;
            r_mul_en    <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_finished  <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_finished <= (r_state == S_DRAIN) && (r_ret_cnt == r_len);
            r_issue_v  <= w_issue && !w_timeout;
            r_mul_en   <= r_issue_v && !w_timeout;
            r_mul_a    <= (r_issue_v && !w_timeout) ? r_op_a : '0;
            r_mul_b    <= (r_issue_v && !w_timeout) ? r_op_b : '0;

            if (w_start_ok) begin
                r_len       <= bus.len;
                r_issue_cnt <= '0;
                r_sent_cnt  <= '0;
                r_ret_cnt   <= '0;
                r_wdog      <= '0;
            end else begin
                if (w_issue)  r_issue_cnt <= r_issue_cnt + CW'(1);
                if (r_mul_en) r_sent_cnt  <= r_sent_cnt + CW'(1);
                if (w_ret_ok) r_ret_cnt   <= r_ret_cnt + CW'(1);
                if (r_mul_en || bus.mul_done) r_wdog <= '0;
                else if (w_idle_cyc)          r_wdog <= r_wdog + WDW'(1);
            end

            if (w_start_bad || w_spurious || w_timeout) r_error <= 1'b1;
            else if (w_start_ok)                        r_error <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mont_batch_ctrl.sv
// Self-checking bench for mont_batch_ctrl with a latency-5 behavioural Montgomery multiplier
// (q=3329, R=2^12) and a reference model of the operand and result buffers.
module tb_mont_batch_ctrl;
    localparam int DEPTH    = 512;
    localparam int AW       = 9;
    localparam int DW       = 12;
    localparam int TIMEOUT  = 1023;
    localparam int LAT      = 5;
    localparam int Q        = 3329;
    localparam int DROP_IDX = 300;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] r;
        logic [AW:0]   idx;
    } pipe_t;

    logic clk;
    logic rst_n;
    mont_batch_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    mont_batch_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int rinv;
    function automatic logic [DW-1:0] mont_ref(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint p;
        p = (longint'(a) * longint'(b)) % Q;
        p = (p * rinv) % Q;
        return DW'(p);
    endfunction

    logic [DW-1:0] op_a    [DEPTH];
    logic [DW-1:0] op_b    [DEPTH];
    logic [DW-1:0] exp_res [DEPTH];

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Behavioural multiplier: in-order pipeline, result valid LAT cycles after its operands.
    pipe_t pipe [LAT];
    int    run_idx;
    logic  prev_en;
    bit    drop_en     = 1'b0;
    bit    inject_done = 1'b0;
    int    last_done_cyc = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe[i] = '0;
            bus.mul_done = 1'b0;
            bus.mul_r    = '0;
            bus.mul_busy = 1'b0;
            run_idx      = 0;
            prev_en      = 1'b0;
        end else begin
            bus.mul_done = (pipe[LAT-1].v && !(drop_en && pipe[LAT-1].idx == (AW+1)'(DROP_IDX)))
                           || inject_done;
            bus.mul_r    = pipe[LAT-1].v ? pipe[LAT-1].r : (inject_done ? 12'hABC : '0);
            if (bus.mul_done) last_done_cyc = cyc;
            for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
            run_idx     = prev_en ? run_idx + 1 : 0;
            pipe[0].v   = bus.mul_en;
            pipe[0].r   = mont_ref(bus.mul_a, bus.mul_b);
            pipe[0].idx = (AW+1)'(run_idx);
            prev_en     = bus.mul_en;
            bus.mul_busy = 1'b0;
            for (int i = 0; i < LAT; i++) if (pipe[i].v) bus.mul_busy = 1'b1;
        end
    end

    // Output monitor: cumulative counters the test sequence snapshots between phases.
    int   en_total = 0, fin_total = 0, seq_err = 0, zero_err = 0;
    int   en_rise_cyc = 0, last_en_cyc = 0, err_rise_cyc = 0, mon_idx = 0;
    logic [DW-1:0] last_en_a, last_en_b;
    logic mon_prev_en = 1'b0, mon_prev_err = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev_en  = 1'b0;
            mon_prev_err = 1'b0;
        end else begin
            if (bus.mul_en) begin
                en_total++;
                if (!mon_prev_en) begin
                    en_rise_cyc = cyc;
                    mon_idx     = 0;
                end else begin
                    mon_idx++;
                end
                last_en_cyc = cyc;
                last_en_a   = bus.mul_a;
                last_en_b   = bus.mul_b;
                if (mon_idx < DEPTH && (bus.mul_a !== op_a[mon_idx] || bus.mul_b !== op_b[mon_idx]))
                    seq_err++;
            end else if (bus.mul_a !== '0 || bus.mul_b !== '0) begin
                zero_err++;
            end
            if (bus.finished) fin_total++;
            if (bus.error && !mon_prev_err) err_rise_cyc = cyc;
            mon_prev_en  = bus.mul_en;
            mon_prev_err = bus.error;
        end
    end

    task automatic load_op(input int addr, input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(addr);
        bus.wr_a    = a;
        bus.wr_b    = b;
        op_a[addr]  = a;
        op_b[addr]  = b;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic check_results(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.rd_addr = AW'(i);
            @(negedge clk);
            check(tag, bus.rd_data, exp_res[i]);
        end
    endtask

    task automatic start_pulse(input int n, output int sc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = (AW+1)'(n);
        sc        = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_batch(input int n, input bit poke7, input string tag);
        int e0, f0, s0, sc, got;
        @(posedge clk);
        e0 = en_total; f0 = fin_total; s0 = seq_err;
        start_pulse(n, sc);
        check({tag, "_ready_low"}, bus.ready, 0);
        if (poke7) begin
            @(negedge clk);
            bus.wr_en = 1'b1; bus.wr_addr = AW'(7); bus.wr_a = 12'hFFF; bus.wr_b = 12'h5A5;
            @(negedge clk);
            bus.wr_en = 1'b0;
        end
        got = 0;
        for (int i = 0; i < n + 200 && got == 0; i++) begin
            @(negedge clk);
            if (bus.finished) begin
                got = 1;
                check({tag, "_ready_at_fin"}, bus.ready, 1);
            end
        end
        check({tag, "_finished_seen"}, got, 1);
        repeat (3) @(posedge clk);
        check({tag, "_en_count"}, en_total - e0, n);
        check({tag, "_en_first"}, en_rise_cyc, sc + 2);
        check({tag, "_en_last"}, last_en_cyc, sc + n + 1);
        check({tag, "_fin_pulses"}, fin_total - f0, 1);
        check({tag, "_order"}, seq_err - s0, 0);
        check({tag, "_error"}, bus.error, 0);
        for (int j = 0; j < n; j++) exp_res[j] = mont_ref(op_a[j], op_b[j]);
    endtask

    task automatic bad_start(input int n, input string tag);
        int e0, sc;
        @(posedge clk);
        e0 = en_total;
        start_pulse(n, sc);
        check({tag, "_error"}, bus.error, 1);
        check({tag, "_ready"}, bus.ready, 1);
        repeat (4) @(posedge clk);
        check({tag, "_no_en"}, en_total - e0, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not end, %0d failed so far", n_fail);
        $fatal(1, "time limit");
    end

    initial begin
        int sc, e0, f0, got, n;
        rst_n = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_a = '0; bus.wr_b = '0;
        bus.start = 1'b0; bus.len = '0; bus.rd_addr = '0;
        rinv = 0;
        for (int x = 1; x < Q; x++) if (((4096 * x) % Q) == 1) rinv = x;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", bus.ready, 1);
        check("rst_finished", bus.finished, 0);
        check("rst_error", bus.error, 0);
        check("rst_mul_en", bus.mul_en, 0);
        check("rst_mul_a", bus.mul_a, 0);
        check("rst_mul_b", bus.mul_b, 0);
        check("rst_rd_data", bus.rd_data, 0);
        rst_n = 1'b1;

        // Full batch of 512 pairs
        for (int i = 0; i < DEPTH; i++) load_op(i, DW'(i), DW'(3328 - i));
        run_batch(DEPTH, 1'b0, "full");
        check_results(DEPTH, "full_res");

        // Minimum batch
        load_op(0, 12'd1234, 12'd2345);
        run_batch(1, 1'b0, "min");
        check("min_a", last_en_a, 1234);
        check("min_b", last_en_b, 2345);
        check_results(1, "min_res");

        // Illegal lengths, with a legal random batch between them to clear error
        bad_start(0, "len0");
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(16, 64);
            for (int i = 0; i < n; i++) load_op(i, DW'($urandom), DW'($urandom));
            run_batch(n, r == 1, "rand");
            check_results(n, "rand_res");
            if (r == 0) bad_start(513, "len513");
        end

        // Spurious result in IDLE
        check("spur_pre_error", bus.error, 0);
        @(posedge clk); inject_done = 1'b1;
        @(posedge clk); inject_done = 1'b0;
        repeat (2) @(negedge clk);
        check("spur_error", bus.error, 1);
        check("spur_ready", bus.ready, 1);
        check_results(DEPTH, "spur_res");

        // Dropped result: watchdog must fire TIMEOUT idle cycles after the last done
        @(posedge clk);
        drop_en = 1'b1; e0 = en_total; f0 = fin_total;
        start_pulse(DEPTH, sc);
        check("drop_error_cleared", bus.error, 0);
        got = 0;
        for (int i = 0; i < DEPTH + TIMEOUT + 200 && got == 0; i++) begin
            @(negedge clk);
            if (bus.error) got = 1;
        end
        check("drop_error_seen", got, 1);
        repeat (3) @(posedge clk);
        drop_en = 1'b0;
        check("drop_idle_cycles", err_rise_cyc - last_done_cyc - 1, TIMEOUT);
        check("drop_ready", bus.ready, 1);
        check("drop_no_finished", fin_total - f0, 0);
        check("drop_en_count", en_total - e0, DEPTH);
        for (int j = 0; j < DEPTH - 1; j++) begin
            int src;
            src = (j < DROP_IDX) ? j : j + 1;
            exp_res[j] = mont_ref(op_a[src], op_b[src]);
        end
        check_results(DEPTH, "drop_res");

        // Reset mid-batch at roughly issue_cnt=100
        @(posedge clk);
        e0 = en_total;
        start_pulse(DEPTH, sc);
        got = 0;
        for (int i = 0; i < 300 && got == 0; i++) begin
            @(posedge clk);
            if (en_total - e0 >= 98) got = 1;
        end
        check("mid_reached", got, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_mul_en", bus.mul_en, 0);
        check("mid_rst_ready", bus.ready, 1);
        check("mid_rst_error", bus.error, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        check("mid_post_mul_en", bus.mul_en, 0);
        check("mid_post_error", bus.error, 0);
        run_batch(16, 1'b0, "post_rst");
        check_results(16, "post_rst_res");

        check("zero_when_idle", zero_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mont_batch_ctrl.md
# mont_batch_ctrl

Batch controller that sits in front of `montgomery_top` and acts as its initiator. A host loads up to DEPTH operand pairs into an internal buffer, then starts a batch. The block streams the pairs to the multiplier one per cycle on `en`/`a`/`b`, collects the in-order `done`/`r` results into a result buffer, and reports completion, or a protocol or timeout error. The host then reads the results back.

## Interface
Parameters:
- DEPTH, 512, operand/result buffer entries
- AW, 9, buffer address width (2^AW == DEPTH)
- DW, 12, operand/result width
- TIMEOUT, 1023, max idle cycles while results are outstanding

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  host operand write strobe
- wr_addr  in  AW  operand write address
- wr_a  in  DW  operand a to store
- wr_b  in  DW  operand b to store
- start  in  1  batch start request
- len  in  AW+1  batch length, legal 1..DEPTH, sampled with start
- rd_addr  in  AW  result read address
- rd_data  out  DW  result at rd_addr, registered, 1-cycle latency
- ready  out  1  high in IDLE
- finished  out  1  one-cycle pulse at batch completion
- error  out  1  sticky error flag
- mul_en  out  1  multiplier operand valid (to `en`)
- mul_a  out  DW  to multiplier `a`
- mul_b  out  DW  to multiplier `b`
- mul_busy  in  1  multiplier `busy`; status only, never gates issue
- mul_done  in  1  multiplier `done`; result valid
- mul_r  in  DW  multiplier `r`

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE, start=1, 1<=len<=DEPTH: latch len, clear issue_cnt, ret_cnt, wdog and error, then go to ISSUE.
- IDLE, start=1, len=0 or len>DEPTH: set error=1 and stay in IDLE.
- Start in ISSUE or DRAIN: ignored.
- ISSUE: operand buffer read at issue_cnt each cycle. The registered mul_en, mul_a and mul_b follow one cycle later. mul_en is high for exactly len consecutive cycles, with pairs in address order 0..len-1. When issue_cnt reaches len, go to DRAIN.
- Whenever mul_en=0, mul_a and mul_b are 0.
- No backpressure: the multiplier is fully pipelined and in-order.
- mul_done=1 in ISSUE or DRAIN with ret_cnt<len: write mul_r to result[ret_cnt] and increment ret_cnt.
- DRAIN, when ret_cnt reaches len: pulse finished on the next cycle and return to IDLE.
- mul_done=1 in IDLE, or with ret_cnt==len: spurious. Set error=1 and do not write the result buffer.
- Watchdog: wdog clears on any mul_en or mul_done cycle and increments otherwise while outstanding (issued minus returned) is >0. When wdog reaches TIMEOUT: set error=1, drop mul_en, go to IDLE, no finished pulse.
- wr_en outside IDLE: ignored, buffer unchanged.
- rd_addr is valid in any state.
- wr_en and start asserted together in IDLE: the write completes, and the batch sees the new data.
- error clears only on reset or on an accepted start.
- Reset mid-batch: the state returns to IDLE. mul_en=0 after the reset edge, and counters and flags clear. Buffer contents are not cleared. `montgomery_top` shares rst_n, so no stale done follows.
- Arithmetic: counters are AW+1 bits wide, so len=DEPTH cannot wrap. mul_r is stored unmodified; no reduction is done here.

## Timing
- Reset values: ready=1, finished=0, error=0, mul_en=0, mul_a=0, mul_b=0, rd_data=0.
- Start accepted at edge k: ready=0 after k, first mul_en=1 after edge k+2, last mul_en after edge k+len+1.
- With fixed multiplier latency L (first done L cycles after its en): finished is high for one cycle, 1 cycle after the last result write. ready=1 on the same cycle as finished.
- Back-to-back batches: start is accepted in the cycle ready=1.
- rd_data: reflects rd_addr from the previous edge.
- Host write: visible to a read-before-issue on the next cycle.
- Error: error rises 1 cycle after the offending event.

## Test plan
- Full batch: load 512 pairs (a=i, b=3328-i), start len=512 with a behavioural multiplier of latency 5 (Montgomery, q=3329). Required: mul_en high exactly 512 consecutive cycles starting 2 cycles after start, one finished pulse, all 512 results read back match the model, error=0.
- Minimum batch: len=1 with a=1234, b=2345. Required: one mul_en cycle carrying 1234/2345, result[0] equals the model value, finished pulses once.
- Illegal length: start with len=0, then with len=513. Required: error=1 after each, ready stays 1, mul_en never asserted.
- Dropped result: the model suppresses done #300 in a len=512 batch. Required: error=1 exactly TIMEOUT idle cycles after the last activity, ready=1, no finished pulse.
- Spurious result: mul_done pulse in IDLE, and a wr_en to addr 7 during ISSUE. Required: error=1, result buffer unchanged, operand[7] unchanged.
- Reset mid-batch: rst_n=0 for 2 cycles at issue_cnt=100. Required: mul_en=0 after the reset edge, ready=1, error=0. A following len=16 batch then completes correctly.
